// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the HI/LO multiply/divide unit
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // R-type funct fields, decoded by ALU control into the op codes above
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

endpackage

// File: rtl/hilo_muldiv_unit_step_core.sv
// rtl/hilo_muldiv_unit_step_core.sv - one iteration (STEP bits) of shift-add multiply or restoring divide
module muldiv_step_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] l;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sum;

  // Multiply: h:l is partial product : remaining multiplier bits.
  // Divide:   h:l is partial remainder : dividend bits not yet consumed.
  always_comb begin
    h     = hi_in;
    l     = lo_in;
    trial = '0;
    sum   = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        trial = {h, l[WIDTH-1]} - {1'b0, operand};
        if (!trial[WIDTH]) begin
          h = trial[WIDTH-1:0];
          l = {l[WIDTH-2:0], 1'b1};
        end else begin
          h = {h[WIDTH-2:0], l[WIDTH-1]};
          l = {l[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum    = {1'b0, h} + (l[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        {h, l} = {sum, l[WIDTH-1:1]};
      end
    end
    hi_out = h;
    lo_out = l;
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/DIV unit owning the architectural HI/LO registers
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int K  = WIDTH / STEP;
  localparam int CW = $clog2(K);

  state_e             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_hi;
  logic               neg_lo;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | rd_req);

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  muldiv_step_core #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step_core (
    .is_div  (is_div),
    .hi_in   (acc_hi),
    .lo_in   (acc_lo),
    .operand (operand),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // For multiply neg_lo is the product sign; for divide it is the quotient sign
  always_comb begin
    prod   = {acc_hi, acc_lo};
    if (neg_lo) prod = -prod;
    fix_hi = is_div ? (neg_hi ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? (neg_lo ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state   <= CALC;
                count   <= CW'(K - 1);
                is_div  <= op[1];
                acc_hi  <= '0;
                acc_lo  <= op[1] ? a_mag : b_mag;
                operand <= op[1] ? b_mag : a_mag;
                // A zero divisor must leave the all-ones quotient un-negated
                neg_lo  <= (a_neg ^ b_neg) & (!op[1] || (b != '0));
                neg_hi  <= a_neg;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (count == '0) state <= FIX;
            else             count <= count - CW'(1);
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers. It is the sequential successor to the ALU-control HI/LO decode.
- Executes MULT, MULTU, DIV, DIVU iteratively and MTHI/MTLO in a single cycle.
- Sits beside the EX-stage ALU. It raises stall to the hazard unit while busy, so the pipeline never reads HI/LO mid-operation.

Parameters:
- WIDTH, 32: operand and HI/LO width; must be even and at least 8.
- STEP, 1: iteration bits retired per cycle (1 or 2); must divide WIDTH.
- K (derived, not overridable): WIDTH/STEP, the number of iteration cycles.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request; op/a/b are valid while high.
- op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved (treated as no-op).
- a, input, WIDTH: rs operand; multiplicand/dividend; MTHI/MTLO source.
- b, input, WIDTH: rt operand; multiplier/divisor.
- flush, input, 1: pipeline flush; aborts any in-flight operation.
- rd_req, input, 1: an MFHI/MFLO is in EX this cycle.
- busy, output, 1: iterative operation in flight.
- done, output, 1: one-cycle pulse when HI/LO have just been updated by mul/div.
- stall, output, 1: combinational, busy & (start | rd_req).
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, hi=0, lo=0, internal accumulators cleared. This holds mid-operation too; there is no partial writeback.
- FSM states:
  - IDLE: accept start. Mul/div op -> CALC; MTHI/MTLO -> stay IDLE.
  - CALC: K cycles, counter counting K-1 down to 0. At 0 -> FIX.
  - FIX: one cycle. Sign correction plus HI/LO write -> IDLE.
- Acceptance: start & ~busy at edge E0 latches operands.
  - Signed ops store magnitudes and result-sign flags.
  - busy is high from E0 through edge E(K+1).
  - At E(K+1) HI/LO are written, busy falls, and done=1 for exactly one cycle.
  - Accept-to-done latency is K+1 cycles (33 for defaults). A new start is accepted in the same cycle done is high.
- MTHI/MTLO: when ~busy & start, write a into hi or lo at the next edge. No busy, no done.
- start while busy: ignored, no side effects. stall=1 keeps the instruction in EX until busy falls.
- rd_req while busy: stall=1. hi/lo outputs always show committed values, never partial results.
- Multiply:
  - Shift-add over magnitudes, STEP multiplier bits per cycle.
  - FIX negates the 2*WIDTH product if the sign flag is set.
  - {hi,lo} = full 2*WIDTH product.
- Divide:
  - Restoring, STEP quotient bits per cycle.
  - lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Divide by zero: lo = all ones, hi = a. The divide still takes full latency with no special timing.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0.
- flush: in CALC or FIX, state goes to IDLE at the next edge. HI/LO stay unchanged and done stays 0.
- flush and start in the same cycle: flush wins and start is dropped, including MTHI/MTLO.
- flush in the same cycle as the FIX edge: flush wins and no writeback occurs.
- Reserved op with start: no state change, busy stays 0.

Decomposition:
- Package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - state enum: IDLE, CALC, FIX.
  - shared funct constants for mult/multu/div/divu/mfhi/mflo/mthi/mtlo, consumed by alu control.
- Sub-module muldiv_step_core: combinational single-iteration datapath (one add-shift or trial-subtract step per STEP bit) with WIDTH and STEP parameters. The top holds the FSM, counter, operand/sign registers and HI/LO.

Test Plan:
- Reset check: rst_n low mid-CALC -> busy=0, done=0, hi=lo=0 immediately (async), no later writeback.
- MULTU a=3, b=5 -> done high 33 cycles after acceptance, hi=0, lo=15. MULT a=0xFFFFFFFF (-1), b=1 -> hi=lo=0xFFFFFFFF.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x64, b=0 -> lo=0xFFFFFFFF, hi=0x64. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flush at CALC cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. Flush coincident with FIX edge -> no writeback.
- Hazards:
  - rd_req asserted while busy -> stall=1 every cycle until done.
  - start while busy -> ignored.
  - MTHI a=0x1234 when idle -> hi=0x1234 next edge, no done.
  - Repeat with STEP=2 -> done at 17 cycles.
